// File: rtl/mem_port_arbiter_if.sv
// rtl/mem_port_arbiter_if.sv - requester and memory-side signal bundle for the port arbiter
interface mem_port_arbiter_if;
  // requester side
  logic        if_req;
  logic        dm_req;
  logic        dm_we;
  logic [3:0]  dm_be;
  logic [31:0] dm_wdata;
  logic        if_ack;
  logic        dm_ack;
  logic [31:0] rdata;
  // memory side
  logic        mem_ready;
  logic [31:0] mem_rdata;
  logic        addr_sel;
  logic        mem_req;
  logic        mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;

  // arbiter view: owns the memory port and the completion strobes
  modport master (
    input  if_req, dm_req, dm_we, dm_be, dm_wdata, mem_ready, mem_rdata,
    output addr_sel, mem_req, mem_we, mem_be, mem_wdata, if_ack, dm_ack, rdata
  );

  // environment view: requesters plus the memory model
  modport slave (
    output if_req, dm_req, dm_we, dm_be, dm_wdata, mem_ready, mem_rdata,
    input  addr_sel, mem_req, mem_we, mem_be, mem_wdata, if_ack, dm_ack, rdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - fetch/data arbiter for a single memory port with starvation guard
module mem_port_arbiter #(
  parameter int STARVE_LIM = 3,
  parameter int CNT_W      = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  mem_port_arbiter_if.master  bus,
  output logic [CNT_W-1:0]    if_grant_cnt,
  output logic [CNT_W-1:0]    dm_grant_cnt
);

  // starve counter must be able to hold STARVE_LIM itself
  localparam int SW = (STARVE_LIM > 0) ? $clog2(STARVE_LIM + 1) : 1;
  localparam logic [SW-1:0]    LIM     = SW'(STARVE_LIM);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    IF_BUSY = 2'd1,
    DM_BUSY = 2'd2
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic          if_grant;
  logic          dm_grant;
  logic [SW-1:0] starve_cnt;

  // next-state decision and memory-port muxing, all derived from the owner state
  always_comb begin
    state_nxt     = state;
    if_grant      = 1'b0;
    dm_grant      = 1'b0;
    bus.addr_sel  = 1'b0;
    bus.mem_req   = 1'b0;
    bus.mem_we    = 1'b0;
    bus.mem_be    = 4'b0000;
    bus.mem_wdata = 32'd0;
    bus.if_ack    = 1'b0;
    bus.dm_ack    = 1'b0;
    bus.rdata     = 32'd0;
    case (state)
      IDLE: begin
        // data wins unless fetch has already waited through LIM data grants
        if (bus.dm_req && (!bus.if_req || (starve_cnt < LIM))) begin
          dm_grant  = 1'b1;
          state_nxt = DM_BUSY;
        end else if (bus.if_req) begin
          if_grant  = 1'b1;
          state_nxt = IF_BUSY;
        end
      end
      IF_BUSY: begin
        bus.mem_req = 1'b1;
        if (bus.mem_ready) begin
          bus.if_ack = 1'b1;
          bus.rdata  = bus.mem_rdata;
          state_nxt  = IDLE;
        end
      end
      DM_BUSY: begin
        bus.mem_req   = 1'b1;
        bus.addr_sel  = 1'b1;
        bus.mem_we    = bus.dm_we;
        bus.mem_be    = bus.dm_be;
        bus.mem_wdata = bus.dm_wdata;
        if (bus.mem_ready) begin
          bus.dm_ack = 1'b1;
          bus.rdata  = bus.mem_rdata;
          state_nxt  = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // owner state, starvation tracking and saturating grant counters
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= IDLE;
      starve_cnt   <= '0;
      if_grant_cnt <= '0;
      dm_grant_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (if_grant) begin
        starve_cnt <= '0;
      end else if (dm_grant) begin
        // a data grant with fetch waiting only happens while below LIM
        starve_cnt <= bus.if_req ? starve_cnt + 1'b1 : '0;
      end
      if (if_grant && (if_grant_cnt != CNT_MAX)) begin
        if_grant_cnt <= if_grant_cnt + 1'b1;
      end
      if (dm_grant && (dm_grant_cnt != CNT_MAX)) begin
        dm_grant_cnt <= dm_grant_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed vector bench for mem_port_arbiter
module tb_mem_port_arbiter;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  mem_port_arbiter_if ifc ();
  mem_port_arbiter_if sif ();

  logic [15:0] if_cnt;
  logic [15:0] dm_cnt;
  logic [1:0]  s_if_cnt;
  logic [1:0]  s_dm_cnt;

  mem_port_arbiter #(.STARVE_LIM(3), .CNT_W(16)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .bus          (ifc),
    .if_grant_cnt (if_cnt),
    .dm_grant_cnt (dm_cnt)
  );

  mem_port_arbiter #(.STARVE_LIM(3), .CNT_W(2)) dut_sat (
    .clk          (clk),
    .rst_n        (rst_n),
    .bus          (sif),
    .if_grant_cnt (s_if_cnt),
    .dm_grant_cnt (s_dm_cnt)
  );

  typedef struct {
    logic [31:0] ir, dr, we, be, wd, rdy, rd;
    logic [31:0] mreq, sel, mwe, mbe, mwd, iack, dack, rdata, icnt, dcnt;
  } vec_t;

  vec_t vecs [18];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic zero_inputs();
    ifc.if_req = 0; ifc.dm_req = 0; ifc.dm_we = 0; ifc.dm_be = 0; ifc.dm_wdata = 0;
    ifc.mem_ready = 0; ifc.mem_rdata = 0;
    sif.if_req = 0; sif.dm_req = 0; sif.dm_we = 0; sif.dm_be = 0; sif.dm_wdata = 0;
    sif.mem_ready = 0; sif.mem_rdata = 0;
  endtask

  initial begin
    logic [7:0] exp_dm;
    int sat_exp [5];
    int n;
    int cyc;

    //           ir dr we be    wd            rdy rd              mreq sel mwe mbe  mwd           iack dack rdata         icnt dcnt
    vecs[0]  = '{1, 0, 0, 0,    0,            0, 'h00500093,      0, 0, 0, 0,    0,            0, 0, 0,            0, 0};
    vecs[1]  = '{1, 0, 0, 0,    0,            0, 'h00500093,      1, 0, 0, 0,    0,            0, 0, 0,            1, 0};
    vecs[2]  = '{1, 0, 0, 0,    0,            1, 'h00500093,      1, 0, 0, 0,    0,            1, 0, 'h00500093,   1, 0};
    vecs[3]  = '{0, 0, 0, 0,    0,            1, 'h12345678,      0, 0, 0, 0,    0,            0, 0, 0,            1, 0};
    vecs[4]  = '{1, 1, 1, 'hF,  'hDEADBEEF,   0, 0,               0, 0, 0, 0,    0,            0, 0, 0,            1, 0};
    vecs[5]  = '{1, 1, 1, 'hF,  'hDEADBEEF,   1, 'hAAAA5555,      1, 1, 1, 'hF,  'hDEADBEEF,   0, 1, 'hAAAA5555,   1, 1};
    vecs[6]  = '{1, 0, 0, 0,    0,            1, 0,               0, 0, 0, 0,    0,            0, 0, 0,            1, 1};
    vecs[7]  = '{1, 0, 0, 0,    0,            1, 'hCAFE,          1, 0, 0, 0,    0,            1, 0, 'hCAFE,       2, 1};
    vecs[8]  = '{0, 1, 1, 3,    'h11223344,   0, 0,               0, 0, 0, 0,    0,            0, 0, 0,            2, 1};
    vecs[9]  = '{0, 1, 1, 3,    'h11223344,   0, 0,               1, 1, 1, 3,    'h11223344,   0, 0, 0,            2, 2};
    vecs[10] = '{0, 1, 1, 3,    'h11223344,   0, 0,               1, 1, 1, 3,    'h11223344,   0, 0, 0,            2, 2};
    vecs[11] = '{0, 1, 1, 3,    'h11223344,   0, 0,               1, 1, 1, 3,    'h11223344,   0, 0, 0,            2, 2};
    vecs[12] = '{0, 1, 1, 3,    'h11223344,   0, 0,               1, 1, 1, 3,    'h11223344,   0, 0, 0,            2, 2};
    vecs[13] = '{0, 1, 1, 3,    'h11223344,   1, 'h55,            1, 1, 1, 3,    'h11223344,   0, 1, 'h55,         2, 2};
    vecs[14] = '{0, 1, 0, 'hF,  0,            0, 0,               0, 0, 0, 0,    0,            0, 0, 0,            2, 2};
    vecs[15] = '{0, 0, 0, 'hF,  0,            0, 0,               1, 1, 0, 'hF,  0,            0, 0, 0,            2, 3};
    vecs[16] = '{0, 0, 0, 'hF,  0,            1, 'h77,            1, 1, 0, 'hF,  0,            0, 1, 'h77,         2, 3};
    vecs[17] = '{0, 0, 0, 0,    0,            0, 0,               0, 0, 0, 0,    0,            0, 0, 0,            2, 3};

    // reset state
    rst_n = 1'b0;
    zero_inputs();
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_mem_req",   ifc.mem_req,   0);
    chk("rst_addr_sel",  ifc.addr_sel,  0);
    chk("rst_mem_we",    ifc.mem_we,    0);
    chk("rst_mem_be",    ifc.mem_be,    0);
    chk("rst_mem_wdata", ifc.mem_wdata, 0);
    chk("rst_if_ack",    ifc.if_ack,    0);
    chk("rst_dm_ack",    ifc.dm_ack,    0);
    chk("rst_rdata",     ifc.rdata,     0);
    chk("rst_if_cnt",    if_cnt,        0);
    chk("rst_dm_cnt",    dm_cnt,        0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // vector table: inputs held for one cycle, outputs compared mid-cycle
    for (int i = 0; i < 18; i++) begin
      ifc.if_req    = vecs[i].ir[0];
      ifc.dm_req    = vecs[i].dr[0];
      ifc.dm_we     = vecs[i].we[0];
      ifc.dm_be     = vecs[i].be[3:0];
      ifc.dm_wdata  = vecs[i].wd;
      ifc.mem_ready = vecs[i].rdy[0];
      ifc.mem_rdata = vecs[i].rd;
      @(negedge clk);
      chk($sformatf("v%0d_mem_req", i),   ifc.mem_req,   vecs[i].mreq);
      chk($sformatf("v%0d_addr_sel", i),  ifc.addr_sel,  vecs[i].sel);
      chk($sformatf("v%0d_mem_we", i),    ifc.mem_we,    vecs[i].mwe);
      chk($sformatf("v%0d_mem_be", i),    ifc.mem_be,    vecs[i].mbe);
      chk($sformatf("v%0d_mem_wdata", i), ifc.mem_wdata, vecs[i].mwd);
      chk($sformatf("v%0d_if_ack", i),    ifc.if_ack,    vecs[i].iack);
      chk($sformatf("v%0d_dm_ack", i),    ifc.dm_ack,    vecs[i].dack);
      chk($sformatf("v%0d_rdata", i),     ifc.rdata,     vecs[i].rdata);
      chk($sformatf("v%0d_if_cnt", i),    if_cnt,        vecs[i].icnt);
      chk($sformatf("v%0d_dm_cnt", i),    dm_cnt,        vecs[i].dcnt);
      @(posedge clk); #1;
    end

    // starvation guard: both requesting, order DM,DM,DM,IF,DM,DM,DM,IF
    exp_dm = 8'b0111_0111;
    ifc.if_req = 1; ifc.dm_req = 1; ifc.dm_we = 0; ifc.dm_be = 4'hF; ifc.dm_wdata = 0;
    ifc.mem_ready = 1; ifc.mem_rdata = 32'h1000;
    n = 0;
    cyc = 0;
    while (n < 8 && cyc < 40) begin
      @(negedge clk);
      if (ifc.if_ack || ifc.dm_ack) begin
        chk($sformatf("starve_both_ack%0d", n), {31'd0, ifc.if_ack & ifc.dm_ack}, 0);
        chk($sformatf("starve_grant%0d_is_dm", n), {31'd0, ifc.dm_ack}, {31'd0, exp_dm[n]});
        n++;
      end
      cyc++;
      if (n < 8) begin
        @(posedge clk); #1;
      end
    end
    chk("starve_acks_seen", n, 8);
    @(posedge clk); #1;
    ifc.if_req = 0; ifc.dm_req = 0; ifc.mem_ready = 0;
    @(negedge clk);
    chk("starve_mem_req_idle", ifc.mem_req, 0);
    chk("starve_if_cnt", if_cnt, 4);
    chk("starve_dm_cnt", dm_cnt, 9);

    // reset during IF_BUSY aborts the fetch without an ack
    @(posedge clk); #1;
    ifc.if_req = 1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("abort_busy_mem_req", ifc.mem_req, 1);
    chk("abort_busy_if_cnt", if_cnt, 5);
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(negedge clk);
    chk("abort_pre_if_ack", ifc.if_ack, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    ifc.mem_ready = 1;
    ifc.mem_rdata = 32'h0BADF00D;
    @(negedge clk);
    chk("abort_mem_req", ifc.mem_req, 0);
    chk("abort_if_ack", ifc.if_ack, 0);
    chk("abort_if_cnt", if_cnt, 0);
    chk("abort_dm_cnt", dm_cnt, 0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("rereq_if_ack", ifc.if_ack, 1);
    chk("rereq_rdata", ifc.rdata, 32'h0BADF00D);
    chk("rereq_if_cnt", if_cnt, 1);
    @(posedge clk); #1;
    ifc.if_req = 0; ifc.mem_ready = 0;

    // saturation on the narrow-counter instance: 1,2,3,3,3
    sat_exp = '{1, 2, 3, 3, 3};
    sif.if_req = 1; sif.mem_ready = 1; sif.mem_rdata = 32'h00500093;
    n = 0;
    cyc = 0;
    while (n < 5 && cyc < 40) begin
      @(negedge clk);
      if (sif.if_ack) begin
        chk($sformatf("sat_if_cnt%0d", n), {30'd0, s_if_cnt}, sat_exp[n]);
        n++;
      end
      cyc++;
      if (n < 5) begin
        @(posedge clk); #1;
      end
    end
    chk("sat_acks_seen", n, 5);
    chk("sat_dm_cnt", {30'd0, s_dm_cnt}, 0);
    @(posedge clk); #1;
    sif.if_req = 0; sif.mem_ready = 0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
